// File: rtl/soqpsk_lut_addr_gen.sv
// soqpsk_lut_addr_gen
// ROM address generator for the 512x14 SOQPSK waveform lookup table.
// A serial bit stream enters through a 4-deep, 1-bit FIFO. One bit is popped
// per symbol and turned into a ternary alpha value. The ROM address is
// {ctx[4:0], sample_index}, registered once per sample tick while run is high.
//
// Build option SOQPSK_PRECODE_EN:
//   defined   - the SOQPSK-TG ternary precoder drives alpha (+1 / 0 / -1).
//   undefined - plain OQPSK: alpha follows the data bit (+1 / -1). Alpha is 0
//               only on underrun. Symbol parity still toggles so the context
//               field keeps the same layout.
module soqpsk_lut_addr_gen #(
    parameter int SPS_LOG2 = 4,
    parameter int ADDR_W   = 9
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              tick,
    input  logic              run,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              sym_strobe,
    output logic              underrun
);

    // Ternary alpha codes. The code 2'b10 is never produced.
    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    localparam logic [2:0]          FIFO_DEPTH = 3'd4;
    localparam logic [SPS_LOG2-1:0] CNT_ZERO   = SPS_LOG2'(0);
    localparam logic [SPS_LOG2-1:0] CNT_ONE    = SPS_LOG2'(1);

`ifdef SOQPSK_PRECODE_EN
    // SOQPSK-TG precoder, expressed on bits (1 = +1, 0 = -1).
    // alpha = 0 when a_k == a_{k-2}. Otherwise alpha = s * a_{k-1} * a_k,
    // where s = +1 for odd symbols (p = 1) and -1 for even symbols (p = 0).
    // The product is negative when an odd number of its factors are -1.
    // That reduces to ~(p ^ a_{k-1} ^ a_k).
    function automatic logic [1:0] precode_alpha(
        input logic a_k,
        input logic a_km1,
        input logic a_km2,
        input logic p
    );
        logic neg;
        neg = ~(p ^ a_km1 ^ a_k);
        if (a_k == a_km2) begin
            precode_alpha = TERN_ZERO;
        end else if (neg) begin
            precode_alpha = TERN_NEG;
        end else begin
            precode_alpha = TERN_POS;
        end
    endfunction
`else
    // Plain OQPSK mapping: the data bit selects +1 or -1 directly.
    function automatic logic [1:0] plain_alpha(input logic a_k);
        if (a_k) begin
            plain_alpha = TERN_POS;
        end else begin
            plain_alpha = TERN_NEG;
        end
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]          fifo_mem_r;
    logic [1:0]          wr_ptr_r;
    logic [1:0]          rd_ptr_r;
    logic [2:0]          fifo_cnt_r;
    logic [SPS_LOG2-1:0] cnt_r;
    logic                p_r;          // parity of the next symbol to be coded
    logic [4:0]          ctx_r;        // {alpha_prev, alpha_cur, p_cur} now in effect
`ifdef SOQPSK_PRECODE_EN
    logic                a_km1_r;      // a_{k-1}, 1 = +1
    logic                a_km2_r;      // a_{k-2}, 1 = +1
`endif

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                step_s;
    logic                boundary_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                pop_s;
    logic                starve_s;
    logic                head_bit_s;
    logic [1:0]          alpha_new_s;
    logic [4:0]          ctx_next_s;
    logic [ADDR_W-1:0]   addr_next_s;

    assign step_s       = tick & run;
    assign boundary_s   = step_s & (cnt_r == CNT_ZERO);
    assign fifo_empty_s = (fifo_cnt_r == 3'd0);
    assign in_ready     = (fifo_cnt_r < FIFO_DEPTH);
    assign push_s       = in_valid & in_ready;
    // No bypass: a pop only ever sees bits pushed in earlier cycles.
    assign pop_s        = boundary_s & ~fifo_empty_s;
    assign starve_s     = boundary_s & fifo_empty_s;
    assign head_bit_s   = fifo_mem_r[rd_ptr_r];

    // Alpha for the symbol starting now. Zero on underrun or when no symbol starts.
    always_comb begin
        alpha_new_s = TERN_ZERO;
        if (pop_s) begin
`ifdef SOQPSK_PRECODE_EN
            alpha_new_s = precode_alpha(head_bit_s, a_km1_r, a_km2_r, p_r);
`else
            alpha_new_s = plain_alpha(head_bit_s);
`endif
        end else begin
            alpha_new_s = TERN_ZERO;
        end
    end

    // Context taking effect this cycle. It shifts alpha_cur into alpha_prev
    // at every boundary, including underrun boundaries.
    always_comb begin
        ctx_next_s = ctx_r;
        if (boundary_s) begin
            ctx_next_s = {ctx_r[2:1], alpha_new_s, p_r};
        end else begin
            ctx_next_s = ctx_r;
        end
    end

    assign addr_next_s = {ctx_next_s, cnt_r};

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            fifo_mem_r <= 4'b0000;
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            fifo_cnt_r <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= in_bit;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 3'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 3'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // In-symbol sample counter. It is parked at 0 while run is low, so the
    // next running tick always opens a fresh symbol.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            cnt_r <= CNT_ZERO;
        end else if (step_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else if (!run) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Symbol parity. It advances only on symbols that carry data.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            p_r <= 1'b0;
        end else if (pop_s) begin
            p_r <= ~p_r;
        end else begin
            p_r <= p_r;
        end
    end

`ifdef SOQPSK_PRECODE_EN
    // Precoder data history. It is left unchanged on underrun symbols.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            a_km1_r <= 1'b1;
            a_km2_r <= 1'b1;
        end else if (pop_s) begin
            a_km2_r <= a_km1_r;
            a_km1_r <= head_bit_s;
        end else begin
            a_km1_r <= a_km1_r;
            a_km2_r <= a_km2_r;
        end
    end
`endif

    // Context register plus the registered ROM address and its strobes.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            ctx_r      <= 5'b00000;
            address    <= {ADDR_W{1'b0}};
            addr_valid <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (step_s) begin
                ctx_r   <= ctx_next_s;
                address <= addr_next_s;
            end
            addr_valid <= step_s;
            sym_strobe <= boundary_s;
            underrun   <= starve_s;
        end
    end

endmodule

// File: tb/tb_soqpsk_lut_addr_gen.sv
// Testbench for soqpsk_lut_addr_gen.
// A behavioural reference model (bit queue, integer +1/0/-1 arithmetic, symbol
// index k) predicts every output cycle by cycle. Directed tables pin the
// specific addresses named for the idle-mark and transition scenarios.
module tb_soqpsk_lut_addr_gen;

    localparam int SPS_LOG2 = 4;
    localparam int ADDR_W   = 9;
    localparam int SPS      = 16;

    logic              clock = 1'b0;
    logic              aclr;
    logic              tick;
    logic              run;
    logic              in_bit;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic              sym_strobe;
    logic              underrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    soqpsk_lut_addr_gen #(.SPS_LOG2(SPS_LOG2), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .aclr       (aclr),
        .tick       (tick),
        .run        (run),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .address    (address),
        .addr_valid (addr_valid),
        .sym_strobe (sym_strobe),
        .underrun   (underrun)
    );

    wire [12:0] obs_vec = {address, addr_valid, sym_strobe, underrun, in_ready};

    // ---------------- reference model ----------------
    bit m_q[$];
    int m_cnt, m_k, m_a1, m_a2, m_aprev, m_acur, m_ctx;
    int exp_addr;
    bit exp_valid, exp_strobe, exp_under;

    function automatic int enc(input int a);
        if (a == 0) return 0;
        else if (a > 0) return 1;
        else return 3;
    endfunction

    function automatic int model_alpha(input int ak);
`ifdef SOQPSK_PRECODE_EN
        int sgn;
        sgn = (m_k % 2 == 1) ? 1 : -1;           // (-1)^(k+1)
        return sgn * m_a1 * (ak - m_a2) / 2;
`else
        return ak;
`endif
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [ADDR_W-1:0] ea;
        logic rdy;
        ea  = exp_addr[ADDR_W-1:0];
        rdy = (m_q.size() < 4);
        return {ea, exp_valid, exp_strobe, exp_under, rdy};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cnt = 0; m_k = 0; m_a1 = 1; m_a2 = 1; m_aprev = 0; m_acur = 0; m_ctx = 0;
        exp_addr = 0; exp_valid = 0; exp_strobe = 0; exp_under = 0;
    endtask

    // Drive one clock cycle and advance the model. Sampling happens 1 time unit after the edge.
    task automatic drive_cycle(input logic t, input logic r, input logic v, input logic b,
                               output logic acc);
        bit step, bnd, push;
        int ak, alpha;
        tick = t; run = r; in_valid = v; in_bit = b;
        step = t && r;
        bnd  = step && (m_cnt == 0);
        push = v && (m_q.size() < 4);
        exp_valid = step; exp_strobe = bnd; exp_under = 0;
        if (bnd) begin
            if (m_q.size() == 0) begin
                alpha = 0;
                exp_under = 1;
                m_aprev = m_acur; m_acur = alpha;
                m_ctx = enc(m_aprev) * 8 + enc(m_acur) * 2 + (m_k % 2);
            end else begin
                ak = m_q.pop_front() ? 1 : -1;
                alpha = model_alpha(ak);
                m_aprev = m_acur; m_acur = alpha;
                m_ctx = enc(m_aprev) * 8 + enc(m_acur) * 2 + (m_k % 2);
                m_a2 = m_a1; m_a1 = ak; m_k++;
            end
        end
        if (step) exp_addr = m_ctx * SPS + m_cnt;
        if (step) m_cnt = (m_cnt + 1) % SPS;
        else if (!r) m_cnt = 0;
        if (push) m_q.push_back(b);
        acc = push;
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        tick = 0; run = 0; in_valid = 0; in_bit = 0;
        aclr = 1'b1;
        @(posedge clock); #1;
        aclr = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic acc;
        int n_under;
        do_reset();
        n_tests++;
        if (obs_vec !== 13'h001) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs_vec, 13'h001);
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'(i % 2), acc);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
        // mid-symbol with 3 bits queued: asynchronous reset between edges
        tick = 0; run = 0; in_valid = 0;
        #2 aclr = 1'b1;
        #1;
        n_tests++;
        if (obs_vec !== 13'h001) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", obs_vec, 13'h001);
        end
        @(posedge clock); #1;
        aclr = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, acc);
        n_under = 0;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL reset_resume cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            if (underrun === 1'b1) n_under++;
        end
        n_tests++;
        if (n_under !== 0) begin
            n_fail++; $display("FAIL reset_no_underrun: got %0d expected 0", n_under);
        end
    endtask

    task automatic test_idle_mark();
        logic acc;
        int tbl[3];
        int sidx;
`ifdef SOQPSK_PRECODE_EN
        tbl = '{0, 16, 0};
`else
        tbl = '{32, 176, 160};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, acc);
        sidx = 0;
        for (int i = 0; i < 48; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL idle_mark cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            if (exp_strobe && sidx < 3) begin
                n_tests++;
                if (address !== tbl[sidx][ADDR_W-1:0]) begin
                    n_fail++; $display("FAIL idle_mark_sym%0d: got %0d expected %0d", sidx, address, tbl[sidx]);
                end
                sidx++;
            end
        end
    endtask

    task automatic test_transition();
        logic acc;
        int tbl[2];
        int sidx;
`ifdef SOQPSK_PRECODE_EN
        tbl = '{32, 144};
`else
        tbl = '{96, 432};
`endif
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, acc);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, acc);
        sidx = 0;
        for (int i = 0; i < 32; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL transition cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            if (exp_strobe && sidx < 2) begin
                n_tests++;
                if (address !== tbl[sidx][ADDR_W-1:0]) begin
                    n_fail++; $display("FAIL transition_sym%0d: got %0d expected %0d", sidx, address, tbl[sidx]);
                end
                sidx++;
            end
        end
    endtask

    task automatic test_underrun();
        logic acc;
        int n_under;
        do_reset();
        n_under = 0;
        for (int i = 0; i < 48; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL underrun cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            n_tests++;
            if (address !== 9'(i % 16)) begin
                n_fail++; $display("FAIL underrun_addr cyc %0d: got %0d expected %0d", i, address, i % 16);
            end
            if (underrun === 1'b1) n_under++;
        end
        n_tests++;
        if (n_under !== 3) begin
            n_fail++; $display("FAIL underrun_count: got %0d expected 3", n_under);
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        bit pend[$];
        int acc_cycle;
        do_reset();
        for (int i = 0; i < 5; i++) pend.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, pend[0], acc);
            if (acc) void'(pend.pop_front());
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL backpressure_fill cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
        end
        n_tests++;
        if (in_ready !== 1'b0 || pend.size() != 1) begin
            n_fail++; $display("FAIL backpressure_full: got ready=%b pending=%0d expected ready=0 pending=1",
                               in_ready, pend.size());
        end
        acc_cycle = -1;
        for (int j = 0; j < 20; j++) begin
            if (pend.size() > 0) begin
                drive_cycle(1'b1, 1'b1, 1'b1, pend[0], acc);
                if (acc) begin void'(pend.pop_front()); acc_cycle = j; end
            end else begin
                drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
            end
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL backpressure_drain cyc %0d: got %h expected %h", j, obs_vec, exp_vec());
            end
        end
        n_tests++;
        if (acc_cycle !== 1) begin
            n_fail++; $display("FAIL backpressure_accept_cycle: got %0d expected 1", acc_cycle);
        end
    endtask

    task automatic test_tick_gating();
        logic acc;
        int n_valid;
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), acc);
        n_valid = 0;
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1'(i % 4 == 0), 1'b1, 1'b1, 1'($urandom_range(0, 1)), acc);
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL tick_gating cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
            if (addr_valid === 1'b1) n_valid++;
        end
        n_tests++;
        if (n_valid !== 16) begin
            n_fail++; $display("FAIL tick_gating_duty: got %0d expected 16", n_valid);
        end
        // run dropped mid-symbol, then restored
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, acc);
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL run_low cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, acc);
        n_tests++;
        if (address[3:0] !== 4'd0 || sym_strobe !== 1'b1 || obs_vec !== exp_vec()) begin
            n_fail++; $display("FAIL run_restart: got %h expected %h (index 0, strobe)", obs_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic acc;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0),
                        1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), acc);
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        aclr = 1'b1; tick = 0; run = 0; in_valid = 0; in_bit = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_idle_mark();
        test_transition();
        test_underrun();
        test_backpressure();
        test_tick_gating();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
